// File: rtl/traffic_light_fsm_if.sv
// Lamp, state-code and pedestrian-button signals of one traffic light.
// master: the light controller; slave: the lamp driver / UART status side.
interface traffic_light_fsm_if;
    logic       ped_button;
    logic [1:0] state_code;
    logic       lamp_green;
    logic       lamp_yellow;
    logic       lamp_red;
    logic       lamp_walk;
    logic       ped_waiting;

    modport master (
        input  ped_button,
        output state_code,
        output lamp_green,
        output lamp_yellow,
        output lamp_red,
        output lamp_walk,
        output ped_waiting
    );

    modport slave (
        output ped_button,
        input  state_code,
        input  lamp_green,
        input  lamp_yellow,
        input  lamp_red,
        input  lamp_walk,
        input  ped_waiting
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// Traffic light sequencer: GREEN -> YELLOW -> RED -> (PED) -> GREEN, with a
// synchronised pedestrian request that may shorten green after a minimum time.
module traffic_light_fsm #(
    parameter int unsigned GREEN_CYCLES     = 60000000,
    parameter int unsigned MIN_GREEN_CYCLES = 24000000,
    parameter int unsigned YELLOW_CYCLES    = 24000000,
    parameter int unsigned RED_CYCLES       = 36000000,
    parameter int unsigned PED_CYCLES       = 48000000
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_fsm_if.master  bus
);

    localparam int unsigned TIMER_W = 32;

    localparam logic [TIMER_W-1:0] GREEN_LAST     = TIMER_W'(GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] MIN_GREEN_LAST = TIMER_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST    = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RED_LAST       = TIMER_W'(RED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PED_LAST       = TIMER_W'(PED_CYCLES - 1);

    // Encoding doubles as the state_code seen by the UART.
    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_RED    = 2'b10,
        ST_PED    = 2'b11
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic                 ped_sync1;
    logic                 ped_sync2;
    logic                 ped_dly;
    logic                 ped_req;
    logic                 ped_req_nxt;
    logic                 ped_edge;

    assign ped_edge = ped_sync2 & ~ped_dly;

    // Phase transitions: full duration, or green cut short by a latched request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GREEN: begin
                if ((timer == GREEN_LAST) || (ped_req && (timer >= MIN_GREEN_LAST))) begin
                    state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    state_nxt = ST_RED;
                end
            end
            ST_RED: begin
                if (timer == RED_LAST) begin
                    state_nxt = ped_req ? ST_PED : ST_GREEN;
                end
            end
            ST_PED: begin
                if (timer == PED_LAST) begin
                    state_nxt = ST_GREEN;
                end
            end
            default: state_nxt = ST_GREEN;
        endcase
    end

    // Serving the request on PED entry beats a press seen on that same cycle.
    always_comb begin
        ped_req_nxt = ped_req;
        if ((state == ST_RED) && (state_nxt == ST_PED)) begin
            ped_req_nxt = 1'b0;
        end else if (ped_edge && (state != ST_PED)) begin
            ped_req_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_sync1       <= 1'b0;
            ped_sync2       <= 1'b0;
            ped_dly         <= 1'b0;
            ped_req         <= 1'b0;
            state           <= ST_GREEN;
            timer           <= '0;
            bus.state_code  <= 2'b00;
            bus.lamp_green  <= 1'b1;
            bus.lamp_yellow <= 1'b0;
            bus.lamp_red    <= 1'b0;
            bus.lamp_walk   <= 1'b0;
            bus.ped_waiting <= 1'b0;
        end else begin
            ped_sync1       <= bus.ped_button;
            ped_sync2       <= ped_sync1;
            ped_dly         <= ped_sync2;
            ped_req         <= ped_req_nxt;
            state           <= state_nxt;
            timer           <= (state_nxt != state) ? '0 : timer + TIMER_W'(1);
            bus.state_code  <= 2'(state_nxt);
            bus.lamp_green  <= (state_nxt == ST_GREEN);
            bus.lamp_yellow <= (state_nxt == ST_YELLOW);
            bus.lamp_red    <= (state_nxt == ST_RED) || (state_nxt == ST_PED);
            bus.lamp_walk   <= (state_nxt == ST_PED);
            bus.ped_waiting <= ped_req_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: vector table, directed corner sequences and
// random button/reset traffic against a phase-level reference model.
module tb_traffic_light_fsm;

    localparam int unsigned G  = 10;
    localparam int unsigned MG = 4;
    localparam int unsigned Y  = 3;
    localparam int unsigned R  = 5;
    localparam int unsigned P  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_light_fsm_if tl_if ();

    traffic_light_fsm #(
        .GREEN_CYCLES     (G),
        .MIN_GREEN_CYCLES (MG),
        .YELLOW_CYCLES    (Y),
        .RED_CYCLES       (R),
        .PED_CYCLES       (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tl_if.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase 0 green, 1 yellow, 2 red, 3 walk.
    int m_phase = 0;
    int m_start = 0;
    bit m_req   = 1'b0;
    bit hist[$] = '{1'b0, 1'b0, 1'b0, 1'b0};

    function automatic int dur(input int ph);
        case (ph)
            0:       return int'(G);
            1:       return int'(Y);
            2:       return int'(R);
            default: return int'(P);
        endcase
    endfunction

    task automatic model_edge(input bit b, input bit r);
        int age;
        int nxt;
        bit press;
        hist.push_front(b);
        void'(hist.pop_back());
        if (r) begin
            m_phase = 0;
            m_start = cyc;
            m_req   = 1'b0;
            hist    = '{1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            age   = cyc - m_start;
            press = hist[2] && !hist[3];
            nxt   = m_phase;
            if (age == dur(m_phase)) begin
                nxt = (m_phase == 0) ? 1 : (m_phase == 1) ? 2 : (m_phase == 2) ? (m_req ? 3 : 0) : 0;
            end else if (m_phase == 0 && m_req && age >= int'(MG)) begin
                nxt = 1;
            end
            if (m_phase == 2 && nxt == 3) m_req = 1'b0;
            else if (press && m_phase != 3) m_req = 1'b1;
            if (nxt != m_phase) m_start = cyc;
            m_phase = nxt;
        end
    endtask

    function automatic logic [6:0] model_vec();
        return {2'(m_phase), m_phase == 0, m_phase == 1, m_phase >= 2, m_phase == 3, m_req};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {tl_if.state_code, tl_if.lamp_green, tl_if.lamp_yellow, tl_if.lamp_red,
                tl_if.lamp_walk, tl_if.ped_waiting};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic step(input bit b, input bit r);
        tl_if.ped_button = b;
        rst = r;
        @(posedge clk);
        cyc++;
        model_edge(b, r);
        #1;
        check("model {code,g,y,r,walk,wait}", 32'(dut_vec()), 32'(model_vec()));
    endtask

    // Length of the phase containing the current sample, stepping with button b.
    task automatic measure(input bit b, output int len);
        logic [1:0] c0;
        c0  = tl_if.state_code;
        len = 1;
        for (int i = 0; i < 100; i++) begin
            step(b, 1'b0);
            if (tl_if.state_code !== c0) return;
            len++;
        end
        n_checks++;
        $display("FAIL measure_timeout cycle %0d: phase %0d still active after %0d cycles", cyc, c0, len);
    endtask

    typedef struct {
        bit         rst;
        bit         btn;
        logic [1:0] code;
        bit         walk;
        bit         pw;
    } vec_t;

    vec_t vec[19];

    initial begin
        int len;
        int cnt;
        bit b;
        logic [1:0] prev;

        tl_if.ped_button = 1'b0;
        rst = 1'b1;

        // Free-run after reset: 10 green, 3 yellow, 5 red, then green again.
        vec[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        for (int i = 1; i < 19; i++) begin
            vec[i].rst  = 1'b0;
            vec[i].btn  = 1'b0;
            vec[i].code = (i < 10) ? 2'b00 : (i < 13) ? 2'b01 : (i < 18) ? 2'b10 : 2'b00;
            vec[i].walk = 1'b0;
            vec[i].pw   = 1'b0;
        end
        for (int i = 0; i < 19; i++) begin
            step(vec[i].btn, vec[i].rst);
            check("tbl_code", 32'(tl_if.state_code), 32'(vec[i].code));
            check("tbl_walk", 32'(tl_if.lamp_walk), 32'(vec[i].walk));
            check("tbl_wait", 32'(tl_if.ped_waiting), 32'(vec[i].pw));
            check("tbl_onehot", 32'(tl_if.lamp_green) + 32'(tl_if.lamp_yellow) + 32'(tl_if.lamp_red), 32'd1);
        end

        // Early green exit: pulse captured on the edge entering green timer 6.
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        measure(1'b0, len);
        check("early_green_len", 32'(len + 6), 32'd9);
        measure(1'b0, len);
        check("early_yellow_len", 32'(len), 32'(Y));
        measure(1'b0, len);
        check("early_red_len", 32'(len), 32'(R));
        check("early_ped_code", 32'(tl_if.state_code), 32'd3);
        check("early_ped_wait_clear", 32'(tl_if.ped_waiting), 32'd0);
        check("early_ped_lamps", 32'({tl_if.lamp_red, tl_if.lamp_walk}), 32'b11);
        measure(1'b0, len);
        check("early_ped_len", 32'(len), 32'(P));
        check("early_back_green", 32'(tl_if.state_code), 32'd0);

        // Minimum green: press right after reset.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        measure(1'b0, len);
        check("min_green_len", 32'(len + 1), 32'(MG));

        // Press during red: red keeps its full length, then walk.
        measure(1'b0, len);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        measure(1'b0, len);
        check("red_press_len", 32'(len + 2), 32'(R));
        check("red_press_ped", 32'(tl_if.state_code), 32'd3);

        // Press during walk is ignored; no walk phase in the next cycle.
        step(1'b1, 1'b0);
        measure(1'b0, len);
        check("ped_press_green", 32'(tl_if.state_code), 32'd0);
        check("ped_press_wait", 32'(tl_if.ped_waiting), 32'd0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b0);
            if (tl_if.state_code == 2'b11) cnt++;
        end
        check("ped_press_no_walk", 32'(cnt), 32'd0);

        // Held button: exactly one walk phase.
        cnt  = 0;
        prev = tl_if.state_code;
        for (int i = 0; i < 80; i++) begin
            step(i < 50, 1'b0);
            if (tl_if.state_code == 2'b11 && prev != 2'b11) cnt++;
            prev = tl_if.state_code;
        end
        check("held_ped_phases", 32'(cnt), 32'd1);

        // Reset at walk timer 2.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 100 && tl_if.state_code != 2'b11; i++) step(1'b0, 1'b0);
        check("reach_ped", 32'(tl_if.state_code), 32'd3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("rst_ped_code", 32'(tl_if.state_code), 32'd0);
        check("rst_ped_walk", 32'(tl_if.lamp_walk), 32'd0);
        check("rst_ped_wait", 32'(tl_if.ped_waiting), 32'd0);
        measure(1'b0, len);
        check("rst_green_len", 32'(len), 32'(G));

        // Random button toggles with rare resets against the model.
        b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) b = ~b;
            step(b, $urandom_range(0, 249) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Sequencing controller for a single traffic light with a pedestrian-crossing request.
- Cycles the light through GREEN, YELLOW, RED and an optional PEDESTRIAN walk phase, with per-phase durations counted in clk cycles.
- Drives the lamp outputs and a 2-bit state code, state_code. The existing UART status transmitter consumes state_code directly as its selectUart input.
- state_code encoding: 00 Green, 01 Yellow, 10 Red, 11 Pedestrian.

Parameters:
- GREEN_CYCLES, 60000000: full green duration (5 s at 12 MHz).
- MIN_GREEN_CYCLES, 24000000: minimum green before a pedestrian request may cut green short.
- YELLOW_CYCLES, 24000000: yellow duration.
- RED_CYCLES, 36000000: red duration.
- PED_CYCLES, 48000000: pedestrian walk duration.
- Constraints: every duration >= 1; MIN_GREEN_CYCLES <= GREEN_CYCLES; every duration < 2^32.

Ports:
- clk  input  1  system clock, 12 MHz. Single clock domain.
- rst  input  1  synchronous, active-high reset.
- ped_button  input  1  raw pedestrian pushbutton. Asynchronous, active-high.
- state_code  output  2  current phase. Connects to the UART selectUart input.
- lamp_green  output  1  green lamp.
- lamp_yellow  output  1  yellow lamp.
- lamp_red  output  1  red lamp.
- lamp_walk  output  1  pedestrian walk lamp.
- ped_waiting  output  1  a pedestrian request is latched and not yet served.

Behaviour:
- All outputs are registered.
- Reset: rst is sampled only on a rising clk edge. Reset values:
  - state = GREEN, timer = 0, ped request latch = 0, synchroniser flops = 0.
  - state_code = 00, lamp_green = 1, all other lamps = 0, ped_waiting = 0.
  - rst asserted mid-phase aborts that phase immediately, including a PED phase, and drops any latched request.
- Button path:
  - ped_button passes through a 2-flop synchroniser, then a rising-edge detector (sync2 = 1 and a delayed copy = 0).
  - A rising edge sets the request latch.
  - A button that goes high before edge k and stays high asserts ped_waiting after edge k+2.
  - Holding the button produces one request only. No debounce; bounces merge into the single latched request.
- Timer:
  - 32-bit up-counter, cleared to 0 on every state transition; otherwise increments by 1 per cycle.
  - A phase of duration D occupies exactly D cycles. The transition occurs on the edge where timer == D-1.
- State machine:
  - GREEN -> YELLOW when timer == GREEN_CYCLES-1.
  - GREEN -> YELLOW early when ped_waiting = 1 and timer >= MIN_GREEN_CYCLES-1, evaluated every cycle.
  - A request latched after MIN_GREEN has elapsed ends green on the cycle after ped_waiting rises.
  - YELLOW -> RED when timer == YELLOW_CYCLES-1.
  - RED -> PED when timer == RED_CYCLES-1 and ped_waiting = 1.
  - RED -> GREEN when timer == RED_CYCLES-1 and ped_waiting = 0.
  - PED -> GREEN when timer == PED_CYCLES-1.
- Lamps per state:
  - GREEN: green only.
  - YELLOW: yellow only.
  - RED: red only.
  - PED: red and walk.
  - Exactly one of green/yellow/red is high in every cycle.
  - Lamps and state_code change on the same edge as the state.
- Request latch:
  - Set by a detected edge in GREEN, YELLOW or RED.
  - Cleared on the RED -> PED transition edge.
  - If an edge is detected on that same cycle, clear wins; the press is dropped.
  - Edges detected while in PED are ignored.
  - Simultaneous set and any other transition: set wins.
- state_code is stable for at least min(duration) cycles per phase. This guarantees the UART sees every change: each message is at most 11 chars × 10 bits × 105 cycles, so the production durations give ample margin.

Test Plan:
- Bench parameters: GREEN=10, MIN_GREEN=4, YELLOW=3, RED=5, PED=6.
- Reset and free-run, no button: after rst is released at edge 0, state_code reads 00 for 10 cycles, 01 for 3 cycles, 10 for 5 cycles, then 00 again (18-cycle period). lamp_walk stays 0 and exactly one colour lamp is high in every cycle.
- Early green exit: pulse ped_button at green timer = 6. ped_waiting rises 2-3 cycles later. state_code goes to 01 the cycle after that, before timer reaches 9. Sequence continues 01(3), 10(5), 11(6) with lamp_red = lamp_walk = 1 in PED, then 00. ped_waiting falls on entry to PED.
- Minimum-green enforcement: press at green timer = 0. ped_waiting is set by timer = 3. state_code changes to 01 exactly when timer == 3 (4 green cycles total), not earlier.
- Press during RED: the request is latched and ped_waiting = 1. The RED phase still lasts its full 5 cycles, then enters 11.
- Press during PED and held button: a press during PED leaves ped_waiting = 0, and the following cycle is 00 → 01 → 10 → 00 with no 11. A button held high for 50 cycles yields exactly one PED phase.
- Reset mid-PED: assert rst at PED timer = 2. On the next edge, state_code = 00, lamp_walk = 0, ped_waiting = 0, and green then lasts a full 10 cycles.
